// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
// The break/extended prefix decode is enabled by defining PS2_BREAK_DECODE_EN.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_code_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ((^data) ^ par) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// First-word-fall-through FIFO holding received scancodes.
// Depth must be a power of two so the pointers wrap naturally.
module ps2_code_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic             valid_r;
    logic             full_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push.
    assign pop_ok_s  = pop & valid_r;
    assign push_ok_s = push & (~full_r | pop_ok_s);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nx_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nx_s = count_r + CW'(1);
            2'b01:   count_nx_s = count_r - CW'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Storage, pointers and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nx_s;
            valid_r <= (count_nx_s != CW'(0));
            full_r  <= (count_nx_s == CW'(DEPTH));
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign valid     = valid_r;
    assign full      = full_r;
    assign count     = count_r;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: input synchronisers, 11-bit frame FSM with
// start/parity/stop checking, inter-edge timeout and a scancode FIFO.
// Defining PS2_BREAK_DECODE_EN folds E0/F0 prefixes into flags on the next code.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    output logic [7:0]                   code_data,
    output logic                         code_ext,
    output logic                         code_brk,
    output logic                         code_valid,
    input  logic                         code_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy,
    output logic                         err_parity,
    output logic                         err_frame,
    output logic                         err_timeout,
    output logic                         overflow
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`ifdef PS2_BREAK_DECODE_EN
    localparam int ENTRY_W = 10;
`else
    localparam int ENTRY_W = 8;
`endif

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic                   fall_edge_s;
    logic                   d_s;

    ps2_state_e             state_r;
    ps2_state_e             state_nx_s;
    logic [7:0]             sr_r;
    logic [2:0]             bit_cnt_r;
    logic                   par_ok_r;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic                   tmo_hit_s;

    logic                   good_s;
    logic                   par_err_s;
    logic                   frm_err_s;
    logic                   push_s;
    logic                   ovf_s;
    logic [ENTRY_W-1:0]     entry_s;

    logic [ENTRY_W-1:0]     fifo_head_s;
    logic                   fifo_valid_s;
    logic                   fifo_full_s;

    logic                   busy_r;
    logic                   err_parity_r;
    logic                   err_frame_r;
    logic                   err_timeout_r;
    logic                   overflow_r;

    // Input synchronisers; idle PS/2 bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r  <= '1;
            data_sync_r <= '1;
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign fall_edge_s = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    assign d_s         = data_sync_r[SYNC_STAGES-1];
    // A falling edge in the same cycle restarts the window, so it wins over the timeout.
    assign tmo_hit_s   = ~fall_edge_s & (state_r != ST_IDLE) & (tmo_cnt_r == TMO_LAST);

    // Frame FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Frame FSM next state: advances only on PS/2 falling edges, or drops to IDLE on timeout.
    always_comb begin
        state_nx_s = state_r;
        if (fall_edge_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!d_s) begin
                        state_nx_s = ST_DATA;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r == 3'd7) begin
                        state_nx_s = ST_PARITY;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end
                ST_PARITY: state_nx_s = ST_STOP;
                ST_STOP:   state_nx_s = ST_IDLE;
                default:   state_nx_s = ST_IDLE;
            endcase
        end else if (tmo_hit_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            state_nx_s = state_r;
        end
    end

    // Frame FSM outputs: classify the stop/start bit outcome on the falling edge.
    always_comb begin
        good_s    = 1'b0;
        par_err_s = 1'b0;
        frm_err_s = 1'b0;
        if (fall_edge_s) begin
            case (state_r)
                ST_IDLE: begin
                    frm_err_s = d_s;
                end
                ST_STOP: begin
                    par_err_s = ~par_ok_r;
                    frm_err_s = par_ok_r & ~d_s;
                    good_s    = par_ok_r & d_s;
                end
                default: begin
                    good_s = 1'b0;
                end
            endcase
        end else begin
            good_s = 1'b0;
        end
    end

    // Shift register, bit counter and latched parity result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r      <= 8'h00;
            bit_cnt_r <= 3'd0;
            par_ok_r  <= 1'b0;
        end else if (fall_edge_s) begin
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= 3'd0;
                end
                ST_DATA: begin
                    sr_r      <= {d_s, sr_r[7:1]};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                ST_PARITY: begin
                    par_ok_r <= odd_parity_ok(sr_r, d_s);
                end
                default: begin
                    par_ok_r <= par_ok_r;
                end
            endcase
        end else if (tmo_hit_s) begin
            bit_cnt_r <= 3'd0;
        end
    end

    // Inter-edge timeout counter; only runs while a frame is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (fall_edge_s || (state_r == ST_IDLE) || tmo_hit_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    logic is_ext_s;
    logic is_brk_s;
    logic ext_pend_r;
    logic brk_pend_r;

    // Prefix bytes only arm a flag; the following real code carries both flags into the FIFO.
    always_comb begin
        is_ext_s = good_s & (sr_r == PS2_EXT_PREFIX);
        is_brk_s = good_s & (sr_r == PS2_BRK_PREFIX);
        push_s   = good_s & ~is_ext_s & ~is_brk_s;
        entry_s  = {ext_pend_r, brk_pend_r, sr_r};
    end

    // Pending prefix flags; cleared by any error, timeout or any push attempt (incl. dropped).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
        end else if (par_err_s || frm_err_s || tmo_hit_s || push_s) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
        end else if (is_ext_s) begin
            ext_pend_r <= 1'b1;
        end else if (is_brk_s) begin
            brk_pend_r <= 1'b1;
        end
    end
`else
    // Every good byte goes straight into the FIFO.
    always_comb begin
        push_s  = good_s;
        entry_s = sr_r;
    end
`endif

    assign ovf_s = push_s & fifo_full_s & ~(fifo_valid_s & code_ready);

    ps2_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (entry_s),
        .pop       (code_ready),
        .head_data (fifo_head_s),
        .valid     (fifo_valid_s),
        .full      (fifo_full_s),
        .count     (fifo_count)
    );

    // Registered status and one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r        <= 1'b0;
            err_parity_r  <= 1'b0;
            err_frame_r   <= 1'b0;
            err_timeout_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            busy_r        <= (state_nx_s != ST_IDLE);
            err_parity_r  <= par_err_s;
            err_frame_r   <= frm_err_s;
            err_timeout_r <= tmo_hit_s;
            overflow_r    <= ovf_s;
        end
    end

    assign code_valid  = fifo_valid_s;
    assign busy        = busy_r;
    assign err_parity  = err_parity_r;
    assign err_frame   = err_frame_r;
    assign err_timeout = err_timeout_r;
    assign overflow    = overflow_r;

`ifdef PS2_BREAK_DECODE_EN
    ps2_code_t head_s;
    assign head_s    = ps2_code_t'(fifo_head_s);
    assign code_data = head_s.code;
    assign code_ext  = head_s.ext;
    assign code_brk  = head_s.brk;
`else
    assign code_data = fifo_head_s;
    assign code_ext  = 1'b0;
    assign code_brk  = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed frames followed by random
// frames, compared against a frame-level reference model (queue of expected codes
// plus expected error/overflow counts). Honours PS2_BREAK_DECODE_EN.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

    localparam int SYNC  = 3;
    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int HALF  = 20;
    localparam int GAP   = 60;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      ps2_clk = 1'b1;
    logic                      ps2_data = 1'b1;
    logic                      code_ready = 1'b0;
    logic [7:0]                code_data;
    logic                      code_ext;
    logic                      code_brk;
    logic                      code_valid;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic                      busy;
    logic                      err_parity;
    logic                      err_frame;
    logic                      err_timeout;
    logic                      overflow;

    ps2_scancode_rx #(
        .SYNC_STAGES    (SYNC),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .code_data   (code_data),
        .code_ext    (code_ext),
        .code_brk    (code_brk),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: expected FIFO contents {ext,brk,code}, pending prefixes, event counts.
    logic [9:0] exp_q[$];
    bit ext_pend_m = 1'b0;
    bit brk_pend_m = 1'b0;
    int exp_par = 0, exp_frm = 0, exp_tmo = 0, exp_ovf = 0;
    int act_par = 0, act_frm = 0, act_tmo = 0, act_ovf = 0;

    task automatic model_clear_flags();
        ext_pend_m = 1'b0;
        brk_pend_m = 1'b0;
    endtask

    task automatic model_push(input logic [9:0] e);
        if (exp_q.size() >= DEPTH) exp_ovf++;
        else exp_q.push_back(e);
    endtask

    task automatic model_good(input logic [7:0] b);
`ifdef PS2_BREAK_DECODE_EN
        if (b == 8'hE0) ext_pend_m = 1'b1;
        else if (b == 8'hF0) brk_pend_m = 1'b1;
        else begin
            model_push({ext_pend_m, brk_pend_m, b});
            model_clear_flags();
        end
`else
        model_push({2'b00, b});
`endif
    endtask

    // Cycle counter and timing markers.
    int cyc = 0;
    int last_fall_cyc = 0;
    int stop_fall_cyc = 0;
    int valid_rise_cyc = -1;
    int tmo_cyc = -1;
    bit prev_valid = 1'b0;
    int ready_mode = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Consumer ready driver: 0 hold low, 1 hold high, otherwise random.
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       code_ready = 1'b0;
            1:       code_ready = 1'b1;
            default: code_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: counts pulses and checks every popped code against the model.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (err_parity)  act_par++;
            if (err_frame)   act_frm++;
            if (err_timeout) begin
                act_tmo++;
                tmo_cyc = cyc;
            end
            if (overflow)    act_ovf++;
            if (code_valid && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = code_valid;
            if (code_valid && code_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("pop_unexpected", {22'd0, code_ext, code_brk, code_data}, 32'hFFFF_FFFF);
                end else begin
                    check_val("pop_data", {22'd0, code_ext, code_brk, code_data}, {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~^b;
        if (bad_par) p = ~p;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        if (bad_par) begin
            exp_par++;
            model_clear_flags();
        end else if (bad_stop) begin
            exp_frm++;
            model_clear_flags();
        end else begin
            model_good(b);
        end
        ps2_bit(!bad_stop);
        stop_fall_cyc = last_fall_cyc;
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    // Start bit plus n data bits (n==9 adds a parity bit), then the clock stops.
    task automatic send_partial(input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
    endtask

    task automatic wait_timeout();
        tmo_cyc = -1;
        exp_tmo++;
        model_clear_flags();
        repeat (TMO + 40) @(posedge clk);
    endtask

    task automatic check_errs(input string tag);
        check_val({tag, "_par"}, act_par, exp_par);
        check_val({tag, "_frm"}, act_frm, exp_frm);
        check_val({tag, "_tmo"}, act_tmo, exp_tmo);
        check_val({tag, "_ovf"}, act_ovf, exp_ovf);
    endtask

    initial begin
        int kind;
        int n;
        logic [7:0] b;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_valid", code_valid, 0);
        check_val("rst_count", fifo_count, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_pulses", {err_parity, err_frame, err_timeout, overflow}, 0);
        check_val("rst_code", {code_ext, code_brk, code_data}, 0);

        // Good 0x2D with consumer ready: valid one cycle after the synced stop edge.
        ready_mode = 1;
        repeat (2) @(posedge clk);
        valid_rise_cyc = -1;
        send_frame(8'h2D, 1'b0, 1'b0);
        check_val("t1_latency", valid_rise_cyc - stop_fall_cyc, SYNC + 1);
        check_val("t1_drained", exp_q.size(), 0);
        check_errs("t1");

        // 0x2D with wrong parity.
        send_frame(8'h2D, 1'b1, 1'b0);
        check_val("t2_count", fifo_count, 0);
        check_errs("t2");

        // Clock stops after 5 data bits, then a good 0x1C.
        send_partial(5);
        @(negedge clk);
        check_val("t3_busy_mid", busy, 1);
        wait_timeout();
        check_val("t3_tmo_window",
                  ((tmo_cyc - last_fall_cyc) >= TMO) && ((tmo_cyc - last_fall_cyc) <= TMO + SYNC + 2), 1);
        @(negedge clk);
        check_val("t3_busy_after", busy, 0);
        check_errs("t3");
        send_frame(8'h1C, 1'b0, 1'b0);
        check_val("t3_drained", exp_q.size(), 0);
        check_errs("t3b");

        // Overflow: five codes with consumer stalled.
        ready_mode = 0;
        repeat (3) @(posedge clk);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
        @(negedge clk);
        check_val("t4_count", fifo_count, DEPTH);
        check_val("t4_valid", code_valid, 1);
        check_errs("t4");
        ready_mode = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_val("t4_drained", exp_q.size(), 0);
        check_val("t4_count_end", fifo_count, 0);

        // Extended break sequence E0 F0 75.
        ready_mode = 0;
        repeat (3) @(posedge clk);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        @(negedge clk);
        check_val("t5_count", fifo_count, exp_q.size());
        ready_mode = 1;
        repeat (20) @(posedge clk);
        check_val("t5_drained", exp_q.size(), 0);
        check_errs("t5");

        // Reset in the middle of a frame, then a clean 0x2D.
        send_partial(4);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear_flags();
        @(negedge clk);
        check_val("t6_busy", busy, 0);
        check_val("t6_count", fifo_count, 0);
        send_frame(8'h2D, 1'b0, 1'b0);
        check_val("t6_drained", exp_q.size(), 0);
        check_errs("t6");

        // Random frames with a randomly stalling consumer.
        ready_mode = 2;
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            case (kind)
                0: send_frame(b, 1'b1, 1'b0);
                1: send_frame(b, 1'b0, 1'b1);
                2: send_frame(b, 1'b1, 1'b1);
                3: begin
                    ps2_bit(1'b1);
                    exp_frm++;
                    model_clear_flags();
                    repeat (GAP) @(posedge clk);
                end
                4: begin
                    n = $urandom_range(0, 9);
                    send_partial(n);
                    wait_timeout();
                end
                default: send_frame(b, 1'b0, 1'b0);
            endcase
            check_errs("rnd");
        end
        ready_mode = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_val("end_drained", exp_q.size(), 0);
        check_val("end_count", fifo_count, 0);
        check_val("end_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
